fetch_stage: RTL and testbench

PC register, instruction-memory request and IF/ID pipeline register for the 5-stage MIPS core. Sits directly upstream of the ID stage and consumes the `stall` produced by hazard detection. Also consumes the branch/jump redirect resolved in ID. Handles an imem with variable latency: the block holds a returned instruction while ID is stalled, and drains an in-flight fetch when a redirect arrives.

---
 rtl/mcpu_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 12 +
 rtl/if_id_reg.sv | 71 +++++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared fetch-stage types and constants
package mcpu_pkg;

  // Fetch control: issuing a request, holding a returned word, or draining a squashed fetch
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bundle
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold/bubble/load select
module if_id_reg
  import mcpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        avail,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_pc4,
  output logic [31:0] ID_instr,
  output logic        ID_valid,
  output logic [31:0] bubble_cnt
);

  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Select hold / bubble / load; stall wins, then a taken redirect squashes, then a fetched word loads
  always_comb begin
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_instr_d   = id_instr_q;
    id_valid_d   = id_valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!stall) begin
      if (!flush && avail) begin
        id_pc_d    = in_pc;
        id_pc4_d   = in_pc + 32'd4;
        id_instr_d = in_instr;
        id_valid_d = 1'b1;
      end else begin
        id_instr_d   = NOP_INSTR;
        id_valid_d   = 1'b0;
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
    end
  end

  // ID register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc_q      <= 32'd0;
      id_pc4_q     <= 32'd0;
      id_instr_q   <= NOP_INSTR;
      id_valid_q   <= 1'b0;
      bubble_cnt_q <= 32'd0;
    end else begin
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ID_pc      = id_pc_q;
  assign ID_pc4     = id_pc4_q;
  assign ID_instr   = id_instr_q;
  assign ID_valid   = id_valid_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, variable-latency imem fetch control and IF/ID register
module fetch_stage
  import mcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  fetch_stage_if.master      imem,
  output logic [31:0]        ID_pc,
  output logic [31:0]        ID_pc4,
  output logic [31:0]        ID_instr,
  output logic               ID_valid,
  output logic [31:0]        bubble_cnt
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  pend_q, pend_d;
  logic         redir_acc;
  logic         avail;
  logic [31:0]  in_instr;

  // Stalled redirects are ignored: hazard detect keeps unresolved branches stalled anyway
  assign redir_acc = redirect_valid & ~stall;
  assign avail     = ((state_q == S_REQ) & imem.imem_ready) | (state_q == S_HOLD);
  assign in_instr  = (state_q == S_HOLD) ? hold_q : imem.imem_rdata;

  assign imem.imem_req  = (state_q != S_HOLD);
  assign imem.imem_addr = pc_q;

  // Next fetch state and PC; a redirect without a response must wait out the in-flight fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    case (state_q)
      S_REQ: begin
        if (redir_acc) begin
          if (imem.imem_ready) begin
            pc_d = redirect_pc;
          end else begin
            pend_d  = redirect_pc;
            state_d = S_DRAIN;
          end
        end else if (imem.imem_ready) begin
          if (!stall) begin
            pc_d = pc_q + 32'd4;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redir_acc) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redir_acc) begin
          pend_d = redirect_pc;
        end
        if (imem.imem_ready) begin
          pc_d    = redir_acc ? redirect_pc : pend_q;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Fetch-side state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= 32'd0;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (redir_acc),
    .avail      (avail),
    .in_pc      (pc_q),
    .in_instr   (in_instr),
    .ID_pc      (ID_pc),
    .ID_pc4     (ID_pc4),
    .ID_instr   (ID_instr),
    .ID_valid   (ID_valid),
    .bubble_cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ID_pc, ID_pc4, ID_instr, bubble_cnt;
  logic        ID_valid;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem.master),
    .ID_pc          (ID_pc),
    .ID_pc4         (ID_pc4),
    .ID_instr       (ID_instr),
    .ID_valid       (ID_valid),
    .bubble_cnt     (bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: where fetching is, whether a word is parked, whether a squashed fetch is draining
  logic [31:0] m_pc;
  logic        m_parked;
  logic [31:0] m_parked_word;
  logic        m_draining;
  logic [31:0] m_target;
  logic [31:0] m_id_pc, m_id_pc4, m_id_instr, m_bubbles;
  logic        m_id_valid;

  int lat_left;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000;
    m_parked = 1'b0;
    m_parked_word = 32'd0;
    m_draining = 1'b0;
    m_target = 32'd0;
    m_id_pc = 32'd0;
    m_id_pc4 = 32'd0;
    m_id_instr = 32'd0;
    m_id_valid = 1'b0;
    m_bubbles = 32'd0;
    lat_left = 0;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [31:0] rpc,
                            input logic rdy, input logic [31:0] rdata);
    logic taken;
    logic have_word;
    logic [31:0] word;
    taken = rv && !st;
    have_word = m_parked || (!m_draining && rdy);
    word = m_parked ? m_parked_word : rdata;
    if (!st) begin
      if (!taken && have_word) begin
        m_id_pc = m_pc;
        m_id_pc4 = m_pc + 32'd4;
        m_id_instr = word;
        m_id_valid = 1'b1;
      end else begin
        m_id_instr = 32'd0;
        m_id_valid = 1'b0;
        m_bubbles = m_bubbles + 32'd1;
      end
    end
    if (m_parked) begin
      if (!st) begin
        m_parked = 1'b0;
        m_pc = taken ? rpc : m_pc + 32'd4;
      end
    end else if (m_draining) begin
      if (taken) m_target = rpc;
      if (rdy) begin
        m_draining = 1'b0;
        m_pc = m_target;
      end
    end else if (taken) begin
      if (rdy) m_pc = rpc;
      else begin
        m_draining = 1'b1;
        m_target = rpc;
      end
    end else if (rdy) begin
      if (!st) m_pc = m_pc + 32'd4;
      else begin
        m_parked = 1'b1;
        m_parked_word = rdata;
      end
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {31'd0, imem.imem_req}, {31'd0, !m_parked});
    chk("imem_addr", imem.imem_addr, m_pc);
    chk("ID_valid", {31'd0, ID_valid}, {31'd0, m_id_valid});
    chk("ID_instr", ID_instr, m_id_instr);
    chk("bubble_cnt", bubble_cnt, m_bubbles);
    if (m_id_valid) begin
      chk("ID_pc", ID_pc, m_id_pc);
      chk("ID_pc4", ID_pc4, m_id_pc4);
      chk("ID_instr_vs_mem", ID_instr, mem_word(ID_pc));
    end
  endtask

  // One clock: drive at negedge, advance model, compare at the following negedge
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy_in);
    logic rdy;
    logic [31:0] rd;
    rdy = rdy_in && imem.imem_req;
    rd = mem_word(imem.imem_addr);
    stall = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    imem.imem_ready = rdy;
    imem.imem_rdata = rdy ? rd : 32'hDEAD_BEEF;
    model_step(st, rv, rpc, rdy, rd);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic rdy;
    logic [31:0] rpc;
    logic rv;
    logic st;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", imem.imem_addr, 32'h0000_3000);
    chk("rst_valid", {31'd0, ID_valid}, 32'd0);
    chk("rst_instr", ID_instr, 32'd0);
    chk("rst_id_pc", ID_pc, 32'd0);
    chk("rst_bubbles", bubble_cnt, 32'd0);
    compare_all();
    rst_n = 1'b1;

    // Streaming fetch with single-cycle imem
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t1_id_pc0", ID_pc, 32'h0000_3000);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t1_addr", imem.imem_addr, 32'h0000_3008);
    chk("t1_id_pc1", ID_pc, 32'h0000_3004);
    chk("t1_bubbles", bubble_cnt, 32'd0);

    // Word returns while ID is stalled: parked, then delivered
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("t2_req", {31'd0, imem.imem_req}, 32'd0);
    chk("t2_frozen", ID_pc, 32'h0000_3004);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t2_id_pc", ID_pc, 32'h0000_3008);
    chk("t2_addr", imem.imem_addr, 32'h0000_300C);

    // Redirect together with a response
    step(1'b0, 1'b1, 32'h0000_3100, 1'b1);
    chk("t3_addr", imem.imem_addr, 32'h0000_3100);
    chk("t3_valid", {31'd0, ID_valid}, 32'd0);
    chk("t3_bubbles", bubble_cnt, 32'd1);

    // Redirect with a slow response in flight, then a second redirect while draining
    step(1'b0, 1'b1, 32'h0000_3200, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t4_addr_stable", imem.imem_addr, 32'h0000_3100);
    step(1'b0, 1'b1, 32'h0000_3300, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t5_addr", imem.imem_addr, 32'h0000_3300);
    chk("t5_bubbles", bubble_cnt, 32'd6);

    // Redirect under stall is ignored
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_3400, 1'b0);
    chk("t6_addr", imem.imem_addr, 32'h0000_3304);
    chk("t6_id_pc", ID_pc, 32'h0000_3300);

    // Asynchronous reset in the middle of a drain
    step(1'b0, 1'b1, 32'h0000_3500, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_addr", imem.imem_addr, 32'h0000_3000);
    chk("t6_rst_valid", {31'd0, ID_valid}, 32'd0);
    chk("t6_rst_bubbles", bubble_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with variable imem latency, including redirects near the top of memory
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else rpc = 32'h0000_3000 + 32'($urandom_range(0, 255) * 4);
      rdy = 1'b0;
      if (imem.imem_req) begin
        if (lat_left == 0) begin
          rdy = 1'b1;
          lat_left = $urandom_range(0, 3);
        end else begin
          lat_left--;
        end
      end
      step(st, rv, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
